uart_rx_fifo: RTL

- Parametrised UART receive channel, successor to the fixed 8-bit receiver/baud-generator pair.
- Contains an oversampling tick generator and a receive FSM. Data bits, parity and stop bits are selectable at run time.
- Received words go into a show-ahead FIFO. Framing, parity and overrun errors are reported.
- Sits between the board RX pin and the consuming logic (command decoder / display path).

---
 rtl/uart_rx_fifo.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// UART receive channel: oversampling tick generator, run-time configurable frame FSM
// (5..8 data bits, none/even/odd parity, 1 or 2 stop bits) feeding a show-ahead FIFO.
module uart_rx_fifo #(
    parameter int OVERSAMPLE = 16,
    parameter int DIV_W      = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx,
    input  logic             rx_en,
    input  logic [DIV_W-1:0] baud_div,
    input  logic [1:0]       data_bits,
    input  logic [1:0]       parity_mode,
    input  logic             stop2,
    input  logic             rd_en,
    output logic [7:0]       rd_data,
    output logic             rd_perr,
    output logic             rx_empty,
    output logic             rx_full,
    output logic [CNT_W-1:0] rx_count,
    output logic             frame_err,
    output logic             overrun,
    input  logic             err_clr
);

    localparam int SW = $clog2(OVERSAMPLE);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [SW-1:0] HALF_M1 = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] FULL_M1 = SW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t state_reg, state_next;

    logic             rx_meta_reg, rx_sync_reg, rx_prev_reg;
    logic [DIV_W-1:0] div_cnt_reg, div_reload;
    logic             tick, start_det;

    logic [SW-1:0]    samp_cnt_reg;
    logic [2:0]       bit_idx_reg;
    logic             stop_idx_reg, stop_bad_reg, par_bit_reg;
    logic [7:0]       data_reg;
    logic [1:0]       cfg_bits_reg, cfg_par_reg;
    logic             cfg_stop2_reg;
    logic             par_en, cfg_odd, last_data, perr_calc;
    logic             samp, do_push, do_ferr;

    logic             push_valid_reg, ferr_pulse_reg;
    logic [8:0]       push_word_reg;

    logic [8:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             frame_err_reg, overrun_reg;
    logic             pop, full, accept, ovr_set;
    logic [8:0]       head_word;

    // Synchroniser and edge-history flops idle high so reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_reg <= 1'b1;
            rx_sync_reg <= 1'b1;
            rx_prev_reg <= 1'b1;
        end else begin
            rx_meta_reg <= rx;
            rx_sync_reg <= rx_meta_reg;
            rx_prev_reg <= rx_sync_reg;
        end
    end

    assign start_det  = (state_reg == S_IDLE) && rx_en && rx_prev_reg && !rx_sync_reg;
    assign div_reload = (baud_div == '0) ? '0 : baud_div - DIV_W'(1);
    assign tick       = rx_en && (div_cnt_reg == '0);

    // Restarting the divider on the start edge keeps sample points centred on each bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            div_cnt_reg <= '0;
        else if (!rx_en || start_det || div_cnt_reg == '0)
            div_cnt_reg <= div_reload;
        else
            div_cnt_reg <= div_cnt_reg - DIV_W'(1);
    end

    assign par_en    = (cfg_par_reg == 2'b01) || (cfg_par_reg == 2'b10);
    assign cfg_odd   = (cfg_par_reg == 2'b10);
    assign last_data = (bit_idx_reg == (3'd4 + {1'b0, cfg_bits_reg}));
    assign perr_calc = par_en && ((^data_reg ^ par_bit_reg) != cfg_odd);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_reg <= S_IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        if (!rx_en) begin
            state_next = S_IDLE;
        end else begin
            case (state_reg)
                S_IDLE:   if (start_det) state_next = S_START;
                S_START:  if (samp) state_next = rx_sync_reg ? S_IDLE : S_DATA;
                S_DATA:   if (samp && last_data) state_next = par_en ? S_PARITY : S_STOP;
                S_PARITY: if (samp) state_next = S_STOP;
                S_STOP:   if (samp && (stop_idx_reg || !cfg_stop2_reg)) state_next = S_IDLE;
                default:  state_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        samp    = 1'b0;
        do_push = 1'b0;
        do_ferr = 1'b0;
        case (state_reg)
            S_START:                  samp = tick && (samp_cnt_reg == HALF_M1);
            S_DATA, S_PARITY, S_STOP: samp = tick && (samp_cnt_reg == FULL_M1);
            default:                  samp = 1'b0;
        endcase
        if (state_reg == S_STOP && samp && (stop_idx_reg || !cfg_stop2_reg)) begin
            if (stop_bad_reg || !rx_sync_reg)
                do_ferr = 1'b1;
            else
                do_push = 1'b1;
        end
    end

    // Frame datapath; configuration is captured once per frame at the start edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            samp_cnt_reg  <= '0;
            bit_idx_reg   <= '0;
            stop_idx_reg  <= 1'b0;
            stop_bad_reg  <= 1'b0;
            par_bit_reg   <= 1'b0;
            data_reg      <= '0;
            cfg_bits_reg  <= '0;
            cfg_par_reg   <= '0;
            cfg_stop2_reg <= 1'b0;
        end else if (state_reg == S_IDLE) begin
            samp_cnt_reg <= '0;
            bit_idx_reg  <= '0;
            stop_idx_reg <= 1'b0;
            stop_bad_reg <= 1'b0;
            if (start_det) begin
                cfg_bits_reg  <= data_bits;
                cfg_par_reg   <= parity_mode;
                cfg_stop2_reg <= stop2;
                data_reg      <= '0;
            end
        end else if (tick) begin
            samp_cnt_reg <= samp ? '0 : samp_cnt_reg + SW'(1);
            if (samp) begin
                case (state_reg)
                    S_DATA: begin
                        data_reg[bit_idx_reg] <= rx_sync_reg;
                        bit_idx_reg           <= bit_idx_reg + 3'd1;
                    end
                    S_PARITY: par_bit_reg <= rx_sync_reg;
                    S_STOP: begin
                        stop_idx_reg <= 1'b1;
                        if (!rx_sync_reg) stop_bad_reg <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            push_valid_reg <= 1'b0;
            ferr_pulse_reg <= 1'b0;
            push_word_reg  <= '0;
        end else begin
            push_valid_reg <= do_push;
            ferr_pulse_reg <= do_ferr;
            push_word_reg  <= {perr_calc, data_reg};
        end
    end

    // Pop is applied before push, so a full FIFO being read still accepts a word.
    assign pop     = rd_en && (count_reg != '0);
    assign full    = (count_reg == CNT_W'(FIFO_DEPTH));
    assign accept  = push_valid_reg && (!full || pop);
    assign ovr_set = push_valid_reg && full && !pop;

    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr_reg] <= push_word_reg;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            frame_err_reg <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            if (accept) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop)    rd_ptr_reg <= rd_ptr_reg + AW'(1);
            count_reg <= count_reg + CNT_W'(accept) - CNT_W'(pop);
            if (ferr_pulse_reg)
                frame_err_reg <= 1'b1;
            else if (err_clr)
                frame_err_reg <= 1'b0;
            if (ovr_set)
                overrun_reg <= 1'b1;
            else if (err_clr)
                overrun_reg <= 1'b0;
        end
    end

    assign head_word = mem[rd_ptr_reg];
    assign rx_empty  = (count_reg == '0);
    assign rx_full   = full;
    assign rx_count  = count_reg;
    assign rd_data   = rx_empty ? 8'h00 : head_word[7:0];
    assign rd_perr   = rx_empty ? 1'b0 : head_word[8];
    assign frame_err = frame_err_reg;
    assign overrun   = overrun_reg;

endmodule
